mux16_to_1: RTL and testbench

- 16:1 multiplexer for WIDTH-bit words (default 64), built as a 4-level binary tree of 2:1 muxes.
- Serves as the half-selector in the register-file read path. Two instances feed a final 2:1 stage to form the 32:1 read-port mux (sel[3:0] here, sel[4] at the top level).
- Provides a zero-latency combinational output for that tree, plus a registered copy for pipelined consumers.

---
 rtl/mux16_to_1_pkg.sv | 21 ++
 rtl/mux16_to_1_mux2_1.sv | 19 +
 rtl/mux16_to_1.sv | 73 +++++++
 tb/tb_mux16_to_1.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mux16_to_1_pkg.sv
// Shared definitions for the register-file read-port multiplexers.
// The 16:1 half-selector, the 32:1 read-port top and the register file all
// draw their word width and word type from here so they cannot drift apart.
package mux16_to_1_pkg;

  // Default data word width for the read path.
  localparam int DEFAULT_WIDTH = 64;

  // Number of words selected by one half-selector and the select width.
  localparam int NUM_WORDS = 16;
  localparam int SEL_BITS  = 4;

  // One register-file word at the default width.
  typedef logic [DEFAULT_WIDTH-1:0] word_t;

  // Number of words produced by tree level lvl (level 0 produces 8).
  function automatic int level_words(input int lvl);
    return NUM_WORDS >> (lvl + 1);
  endfunction

endpackage

// File: rtl/mux16_to_1_mux2_1.sv
// 2:1 word multiplexer: the leaf cell of the read-port select tree.
// Passes i0 when sel is 0 and i1 when sel is 1. Purely combinational.
module mux2_1
  import mux16_to_1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  // Select between the two candidate words.
  always_comb begin
    out = sel ? i1 : i0;
  end

endmodule

// File: rtl/mux16_to_1.sv
// 16:1 word multiplexer used as one half of the register-file 32:1 read port.
// Built as a 4-level binary tree of mux2_1 cells: level n is steered by
// sel[n], so the low select bit picks within adjacent word pairs first.
// out is the zero-latency tree output; out_q is a registered copy of it for
// pipelined consumers, one cycle behind out and cleared by reset.
// There is no handshake: out is valid whenever sel is known, and out_q is
// valid on every cycle after the first edge with reset high.
module mux16_to_1
  import mux16_to_1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0][WIDTH-1:0] i,
  input  logic [3:0]            sel,
  output logic [WIDTH-1:0]      out,
  output logic [WIDTH-1:0]      out_q
);

  // Intermediate tree levels: 8, 4 and 2 words respectively.
  logic [7:0][WIDTH-1:0] lvl0;
  logic [3:0][WIDTH-1:0] lvl1;
  logic [1:0][WIDTH-1:0] lvl2;

  // Level 0: pair (i[2k], i[2k+1]) under sel[0].
  for (genvar k = 0; k < 8; k++) begin : g_lvl0
    mux2_1 #(.WIDTH(WIDTH)) u_mux (
      .i0  (i[2*k]),
      .i1  (i[2*k+1]),
      .sel (sel[0]),
      .out (lvl0[k])
    );
  end

  // Level 1: pair adjacent level-0 results under sel[1].
  for (genvar k = 0; k < 4; k++) begin : g_lvl1
    mux2_1 #(.WIDTH(WIDTH)) u_mux (
      .i0  (lvl0[2*k]),
      .i1  (lvl0[2*k+1]),
      .sel (sel[1]),
      .out (lvl1[k])
    );
  end

  // Level 2: pair adjacent level-1 results under sel[2].
  for (genvar k = 0; k < 2; k++) begin : g_lvl2
    mux2_1 #(.WIDTH(WIDTH)) u_mux (
      .i0  (lvl1[2*k]),
      .i1  (lvl1[2*k+1]),
      .sel (sel[2]),
      .out (lvl2[k])
    );
  end

  // Level 3: final choice between the two halves under sel[3].
  mux2_1 #(.WIDTH(WIDTH)) u_mux_root (
    .i0  (lvl2[0]),
    .i1  (lvl2[1]),
    .sel (sel[3]),
    .out (out)
  );

  // Registered copy of the tree output; reset only clears this register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_mux16_to_1.sv
// Bench for mux16_to_1: directed vectors drive i/sel/reset once per cycle and
// push the hand-computed expected out and out_q into queues; a monitor on the
// falling edge pops them and compares against the DUT.
module tb_mux16_to_1;

  localparam int W = 64;

  // Clock and reset block.
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0][W-1:0] din;
  logic [3:0]         sel;
  logic [W-1:0]       out;
  logic [W-1:0]       out_q;

  mux16_to_1 dut (
    .clk   (clk),
    .reset (reset),
    .i     (din),
    .sel   (sel),
    .out   (out),
    .out_q (out_q)
  );

  // Test-plan data words.
  logic [W-1:0] vals [16] = '{
    64'd64357, 64'd26000, 64'd24556, 64'd12328,
    64'd63,    64'd31,    64'd132346, 64'd7,
    64'd157,   64'd2803,  64'd308,   64'd64,
    64'd27,    64'd879,   64'd538129, 64'd1327
  };

  // Scoreboard: expected out, expected out_q after the next edge, step tag.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_reg_q[$];
  int           tag_q[$];

  int checks   = 0;
  int failures = 0;
  int step_id  = 0;

  // Monitor state carried from one falling edge to the next.
  bit           have_prev = 1'b0;
  logic [W-1:0] prev_reg;
  int           prev_tag;
  logic [W-1:0] m_out;
  int           m_tag;

  task automatic check(input string name, input int tag,
                       input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=0x%0h expected=0x%0h", name, tag, act, exp);
    end
  endtask

  // Driver: apply one vector for one cycle and record what it should produce.
  task automatic step(input logic [3:0] s, input logic r, input logic [W-1:0] e);
    sel   = s;
    reset = r;
    exp_q.push_back(e);
    exp_reg_q.push_back(r ? '0 : e);
    tag_q.push_back(step_id);
    step_id++;
    @(posedge clk);
    #2;
  endtask

  // Monitor: out is checked in the cycle its vector is applied; out_q is
  // checked one cycle later, after the edge that captured that vector.
  initial begin
    forever begin
      @(negedge clk);
      if (have_prev) check("out_q", prev_tag, out_q, prev_reg);
      if (exp_q.size() > 0) begin
        m_out    = exp_q.pop_front();
        prev_reg = exp_reg_q.pop_front();
        m_tag    = tag_q.pop_front();
        check("out", m_tag, out, m_out);
        prev_tag  = m_tag;
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Directed stimulus.
  initial begin
    reset = 1'b1;
    sel   = 4'd0;
    din   = '0;
    @(posedge clk);
    #2;
    for (int k = 0; k < 16; k++) din[k] = vals[k];

    // Reset state: out_q cleared, out still follows i[0].
    step(4'd0, 1'b1, 64'd64357);

    // Combinational sweep of all selects.
    for (int s = 0; s < 16; s++) step(4'(s), 1'b0, vals[s]);

    // Registered path: sel=2 then sel=13 on consecutive cycles.
    step(4'd2,  1'b0, 64'd24556);
    step(4'd13, 1'b0, 64'd879);

    // Reset mid-operation, then release.
    step(4'd0, 1'b1, 64'd64357);
    step(4'd0, 1'b0, 64'd64357);

    // Data change with select held: out follows now, out_q on the next edge.
    step(4'd9, 1'b0, 64'd2803);
    din[9] = 64'd4096;
    step(4'd9, 1'b0, 64'd4096);

    // Width / bit integrity.
    din     = '0;
    din[15] = 64'hFFFF_FFFF_FFFF_FFFF;
    din[0]  = 64'h8000_0000_0000_0001;
    step(4'd15, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    step(4'd0,  1'b0, 64'h8000_0000_0000_0001);
    step(4'd7,  1'b0, 64'h0);

    // Distinct word-index pattern: catches swapped pairs anywhere in the tree.
    for (int k = 0; k < 16; k++) din[k] = W'(k + 256);
    for (int s = 0; s < 16; s++) step(4'(s), 1'b0, W'(s + 256));

    // Drain the last out_q check, then confirm the scoreboard emptied.
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
